// File: rtl/dcache_responder.sv
// ---------------------------------------------------------------------------
// dcache_responder
//
// Direct-mapped, write-back, write-allocate data cache between the MEM stage
// of the 5-stage core and the word-wide backing RAM. Hits are answered
// combinationally in the issuing cycle. A miss raises mem_stall while the FSM
// writes back a dirty victim line and then refills the line one word per
// RAM beat.
//
// Optional feature: define CACHE_STATS_EN to build the hit/miss counters.
// Without it hit_cnt and miss_cnt are tied to zero and no counter flops exist.
//
// Ports
//   clk        in   1   main clock, rising edge
//   rst        in   1   asynchronous reset, active-low
//   mem_ren    in   1   core read request
//   mem_wen    in   1   core write request (wins over mem_ren)
//   mem_addr   in   32  core byte address, bits [1:0] ignored
//   mem_dout   in   32  core write data
//   mem_din    out  32  read data to core, zero while there is no hit
//   mem_stall  out  1   freeze core pipeline
//   ram_req    out  1   backing RAM beat request
//   ram_we     out  1   1 = write beat, 0 = read beat
//   ram_addr   out  32  word-aligned beat address
//   ram_wdata  out  32  write-back data
//   ram_rdata  in   32  refill data, valid with ram_ack
//   ram_ack    in   1   one-cycle beat completion
//   hit_cnt    out  32  hits seen in IDLE
//   miss_cnt   out  32  misses that started a line transfer
// ---------------------------------------------------------------------------
module dcache_responder #(
   parameter int LINE_WORDS = 4,
   parameter int LINES      = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ren,
   input  logic        mem_wen,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_dout,
   output logic [31:0] mem_din,
   output logic        mem_stall,
   output logic        ram_req,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata,
   input  logic        ram_ack,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int OFS_W = $clog2(LINE_WORDS);
   localparam int IDX_W = $clog2(LINES);
   localparam int TAG_W = 30 - OFS_W - IDX_W;
   localparam int WORDS = LINES * LINE_WORDS;
   localparam logic [OFS_W-1:0] LAST_BEAT = OFS_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WB,
      S_FILL,
      S_DONE
   } state_t;

   state_t state;

   // Line bookkeeping and storage, all flops with asynchronous read.
   logic [LINES-1:0] valid_q;
   logic [LINES-1:0] dirty_q;
   logic [TAG_W-1:0] tag_q  [LINES];
   logic [31:0]      data_q [WORDS];

   // Request captured when the FSM leaves IDLE; the core input is ignored
   // from then until the line transfer is over.
   logic [TAG_W-1:0] lat_tag;
   logic [IDX_W-1:0] lat_idx;
   logic [OFS_W-1:0] beat;
   logic [OFS_W-1:0] next_beat;

   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] req_idx;
   logic [OFS_W-1:0] req_ofs;
   logic             req;
   logic             hit;
   logic             idle;
   logic             do_write;
   logic             do_miss;
   logic             beat_ack;
   logic             unused_byte_bits;

   assign req_tag = mem_addr[31 -: TAG_W];
   assign req_idx = mem_addr[IDX_W+OFS_W+1 : OFS_W+2];
   assign req_ofs = mem_addr[OFS_W+1 : 2];
   assign unused_byte_bits = ^mem_addr[1:0];

   assign req       = mem_ren | mem_wen;
   assign hit       = req & valid_q[req_idx] & (tag_q[req_idx] == req_tag);
   assign idle      = (state == S_IDLE);
   assign mem_stall = (req & ~hit) | ~idle;
   assign mem_din   = hit ? data_q[{req_idx, req_ofs}] : 32'h0;

   // Writes and misses only act in IDLE; while a transfer is running the
   // core is frozen and its request is not looked at.
   assign do_write  = idle & hit & mem_wen;
   assign do_miss   = idle & req & ~hit;

   // An acknowledge only counts while a beat is actually outstanding.
   assign beat_ack  = ram_req & ram_ack;
   assign next_beat = beat + OFS_W'(1);

   // Control FSM. The RAM-side outputs are registered and are set up one
   // edge ahead, so consecutive beats follow each other with no idle cycle
   // and ram_req drops on the edge that samples the final acknowledge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         valid_q   <= '0;
         dirty_q   <= '0;
         lat_tag   <= '0;
         lat_idx   <= '0;
         beat      <= '0;
         ram_req   <= 1'b0;
         ram_we    <= 1'b0;
         ram_addr  <= 32'h0;
         ram_wdata <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (do_write) begin
                  dirty_q[req_idx] <= 1'b1;
               end else if (do_miss) begin
                  lat_tag <= req_tag;
                  lat_idx <= req_idx;
                  beat    <= '0;
                  ram_req <= 1'b1;
                  if (valid_q[req_idx] && dirty_q[req_idx]) begin
                     state     <= S_WB;
                     ram_we    <= 1'b1;
                     ram_addr  <= {tag_q[req_idx], req_idx, {OFS_W{1'b0}}, 2'b00};
                     ram_wdata <= data_q[{req_idx, {OFS_W{1'b0}}}];
                  end else begin
                     state    <= S_FILL;
                     ram_we   <= 1'b0;
                     ram_addr <= {req_tag, req_idx, {OFS_W{1'b0}}, 2'b00};
                  end
               end
            end
            S_WB: begin
               if (beat_ack) begin
                  if (beat == LAST_BEAT) begin
                     // Victim is out; turn straight into the first refill beat.
                     state    <= S_FILL;
                     beat     <= '0;
                     ram_we   <= 1'b0;
                     ram_addr <= {lat_tag, lat_idx, {OFS_W{1'b0}}, 2'b00};
                  end else begin
                     beat      <= next_beat;
                     ram_addr  <= {tag_q[lat_idx], lat_idx, next_beat, 2'b00};
                     ram_wdata <= data_q[{lat_idx, next_beat}];
                  end
               end
            end
            S_FILL: begin
               if (beat_ack) begin
                  if (beat == LAST_BEAT) begin
                     state            <= S_DONE;
                     ram_req          <= 1'b0;
                     valid_q[lat_idx] <= 1'b1;
                     dirty_q[lat_idx] <= 1'b0;
                  end else begin
                     beat     <= next_beat;
                     ram_addr <= {lat_tag, lat_idx, next_beat, 2'b00};
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Tag and data arrays carry no reset: a line is only ever read once its
   // valid bit is set, and valid is cleared by reset.
   always_ff @(posedge clk) begin
      if (do_write) begin
         data_q[{req_idx, req_ofs}] <= mem_dout;
      end
      if ((state == S_FILL) && beat_ack) begin
         data_q[{lat_idx, beat}] <= ram_rdata;
         if (beat == LAST_BEAT) begin
            tag_q[lat_idx] <= lat_tag;
         end
      end
   end

`ifdef CACHE_STATS_EN
   // A hit is counted once per IDLE cycle it is presented; a miss is counted
   // when it starts a line transfer. Both counters wrap naturally.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_cnt  <= 32'h0;
         miss_cnt <= 32'h0;
      end else begin
         if (idle && hit) begin
            hit_cnt <= hit_cnt + 32'd1;
         end
         if (do_miss) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end
`else
   assign hit_cnt  = 32'h0;
   assign miss_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// ---------------------------------------------------------------------------
// tb_dcache_responder
//
// Self-checking bench for dcache_responder with its default geometry
// (4 words per line, 64 lines). A behavioural RAM answers beats and logs
// them; a line-level cache model predicts read data, the exact RAM beat
// sequence of every access, and the statistics counters.
// ---------------------------------------------------------------------------
module tb_dcache_responder;

   localparam int LW = 4;
   localparam int NL = 64;

   logic        clk;
   logic        rst;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        mem_stall;
   logic        ram_req;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        ram_ack;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   dcache_responder dut (
      .clk       (clk),
      .rst       (rst),
      .mem_ren   (mem_ren),
      .mem_wen   (mem_wen),
      .mem_addr  (mem_addr),
      .mem_dout  (mem_dout),
      .mem_din   (mem_din),
      .mem_stall (mem_stall),
      .ram_req   (ram_req),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .ram_ack   (ram_ack),
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [31:0] addr;
      logic [31:0] data;
   } beat_t;

   typedef struct {
      bit          wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_din;
      int          exp_wb;
      int          exp_rd;
      int          exp_stalls;
   } vec_t;

   int checks_total  = 0;
   int checks_passed = 0;

   beat_t dut_log[$];
   beat_t exp_log[$];

   logic [31:0] ram_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   // Responder controls.
   int          ack_pct    = 100;
   bit          stray_en   = 1'b0;
   logic [31:0] block_addr = 32'hFFFF_FFFF;

   // Reference model state.
   bit          m_valid [NL];
   bit          m_dirty [NL];
   logic [31:0] m_tag   [NL];
   logic [31:0] m_data  [NL][LW];
   int          exp_hits;
   int          exp_misses;

   logic [31:0] last_din;
   int          last_stalls;

   // Power-on RAM contents: 0x100..0x10C hold 0xA0..0xA3, every other word
   // is derived from its own address.
   function automatic logic [31:0] initWord(input logic [31:0] a);
      if (a >= 32'h100 && a <= 32'h10C)
         return 32'hA0 + ((a - 32'h100) >> 2);
      return {~a[15:0], a[15:0]};
   endfunction

   function automatic logic [31:0] ramRead(input logic [31:0] a);
      if (ram_mem.exists(a))
         return ram_mem[a];
      return initWord(a);
   endfunction

   function automatic logic [31:0] refRead(input logic [31:0] a);
      if (ref_mem.exists(a))
         return ref_mem[a];
      return initWord(a);
   endfunction

   // Backing RAM: decides the acknowledge half a cycle before each rising
   // edge and logs every beat it completes. Stray acknowledges with junk
   // data are thrown in while no beat is outstanding.
   initial begin
      beat_t b;
      ram_ack   = 1'b0;
      ram_rdata = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         ram_ack = 1'b0;
         if (ram_req && rst && (ram_addr != block_addr) &&
             ($urandom_range(99) < ack_pct)) begin
            ram_ack = 1'b1;
            b.we    = ram_we;
            b.addr  = ram_addr;
            if (ram_we) begin
               ram_mem[ram_addr] = ram_wdata;
               b.data = ram_wdata;
            end else begin
               ram_rdata = ramRead(ram_addr);
               b.data    = ram_rdata;
            end
            dut_log.push_back(b);
         end else if (!ram_req && stray_en && ($urandom_range(9) == 0)) begin
            ram_ack   = 1'b1;
            ram_rdata = $urandom;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time 2000000, required completion earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks_total++;
      if (actual === expected)
         checks_passed++;
      else
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Advance to two time units after the next falling edge.
   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
      #2;
   endtask

   task automatic modelReset();
      for (int i = 0; i < NL; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      exp_hits   = 0;
      exp_misses = 0;
   endtask

   // Line-level view of one access: evict if dirty, refill, then read or
   // merge the word. Fills exp_log with the RAM beats this must cause.
   task automatic modelAccess(input bit wen, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] din);
      logic [31:0] tag;
      logic [31:0] a;
      int          idx;
      int          ofs;
      beat_t       b;
      tag = addr >> 10;
      idx = int'((addr >> 4) % NL);
      ofs = int'((addr >> 2) % LW);
      exp_log.delete();
      if (!(m_valid[idx] && m_tag[idx] == tag)) begin
         exp_misses++;
         if (m_valid[idx] && m_dirty[idx]) begin
            for (int k = 0; k < LW; k++) begin
               a = m_tag[idx] * 1024 + idx * 16 + k * 4;
               ref_mem[a] = m_data[idx][k];
               b.we = 1'b1; b.addr = a; b.data = m_data[idx][k];
               exp_log.push_back(b);
            end
         end
         for (int k = 0; k < LW; k++) begin
            a = tag * 1024 + idx * 16 + k * 4;
            m_data[idx][k] = refRead(a);
            b.we = 1'b0; b.addr = a; b.data = m_data[idx][k];
            exp_log.push_back(b);
         end
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_dirty[idx] = 1'b0;
      end
      exp_hits++;
      din = m_data[idx][ofs];
      if (wen) begin
         m_data[idx][ofs] = wdata;
         m_dirty[idx]     = 1'b1;
      end
   endtask

   task automatic startAccess(input bit wen, input bit ren, input logic [31:0] addr,
                              input logic [31:0] wdata);
      dut_log.delete();
      mem_addr = addr;
      mem_dout = wdata;
      mem_wen  = wen;
      mem_ren  = ren;
      #1;
   endtask

   // Wait out the stall, take the read data, let the access commit on the
   // next edge, then compare against the model.
   task automatic finishAccess(input bit wen, input logic [31:0] addr,
                               input logic [31:0] wdata);
      int          stalls;
      logic [31:0] exp_din;
      int          n;
      stalls = 0;
      while (mem_stall && stalls < 400) begin
         nextCycle();
         stalls++;
      end
      if (mem_stall)
         checkOutput("stall_timeout", 32'd1, 32'd0);
      last_din    = mem_din;
      last_stalls = stalls;
      nextCycle();
      mem_ren = 1'b0;
      mem_wen = 1'b0;
      #1;
      modelAccess(wen, addr, wdata, exp_din);
      if (!wen)
         checkOutput($sformatf("read_data@%08h", addr), last_din, exp_din);
      checkOutput($sformatf("beat_count@%08h", addr), dut_log.size(), exp_log.size());
      n = (dut_log.size() < exp_log.size()) ? dut_log.size() : exp_log.size();
      for (int k = 0; k < n; k++) begin
         checkOutput($sformatf("beat%0d_we@%08h", k, addr), dut_log[k].we, exp_log[k].we);
         checkOutput($sformatf("beat%0d_addr@%08h", k, addr), dut_log[k].addr, exp_log[k].addr);
         checkOutput($sformatf("beat%0d_data@%08h", k, addr), dut_log[k].data, exp_log[k].data);
      end
   endtask

   task automatic applyStimulus(input bit wen, input bit ren, input logic [31:0] addr,
                                input logic [31:0] wdata);
      startAccess(wen, ren, addr, wdata);
      finishAccess(wen, addr, wdata);
   endtask

   task automatic checkCounters(input string tag);
`ifdef CACHE_STATS_EN
      checkOutput({"hit_cnt_", tag}, hit_cnt, exp_hits);
      checkOutput({"miss_cnt_", tag}, miss_cnt, exp_misses);
`else
      checkOutput({"hit_cnt_", tag}, hit_cnt, 32'h0);
      checkOutput({"miss_cnt_", tag}, miss_cnt, 32'h0);
`endif
   endtask

   initial begin
      vec_t        vecs [6];
      beat_t       saved[$];
      logic [31:0] wb_exp [LW];
      int          wb_n;
      int          rd_n;
      int          guard;
      bit          w;
      bit          r;
      logic [31:0] a;

      vecs[0] = '{1'b0, 32'h100, 32'h0,         32'hA0,        0, 4, 6};
      vecs[1] = '{1'b0, 32'h104, 32'h0,         32'hA1,        0, 0, 0};
      vecs[2] = '{1'b1, 32'h108, 32'hDEAD,      32'h0,         0, 0, 0};
      vecs[3] = '{1'b0, 32'h108, 32'h0,         32'hDEAD,      0, 0, 0};
      vecs[4] = '{1'b0, 32'h500, 32'h0,         32'hFAFF_0500, 4, 4, 10};
      vecs[5] = '{1'b1, 32'h50C, 32'h1234_5678, 32'h0,         0, 0, 0};
      wb_exp  = '{32'hA0, 32'hA1, 32'hDEAD, 32'hA3};

      rst      = 1'b0;
      mem_ren  = 1'b0;
      mem_wen  = 1'b0;
      mem_addr = 32'h0;
      mem_dout = 32'h0;
      modelReset();

      // Reset state.
      nextCycle();
      nextCycle();
      checkOutput("rst_stall", mem_stall, 32'h0);
      checkOutput("rst_ram_req", ram_req, 32'h0);
      checkOutput("rst_ram_we", ram_we, 32'h0);
      checkOutput("rst_ram_addr", ram_addr, 32'h0);
      checkOutput("rst_ram_wdata", ram_wdata, 32'h0);
      checkOutput("rst_mem_din", mem_din, 32'h0);
      checkCounters("rst");
      rst = 1'b1;
      nextCycle();

      // Directed table: fill, hits, write hit, dirty eviction.
      $display("[TB] directed table");
      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i].wen, !vecs[i].wen, vecs[i].addr, vecs[i].wdata);
         wb_n = 0;
         rd_n = 0;
         foreach (dut_log[k]) begin
            if (dut_log[k].we) wb_n++;
            else               rd_n++;
         end
         if (!vecs[i].wen)
            checkOutput($sformatf("vec%0d_din", i), last_din, vecs[i].exp_din);
         checkOutput($sformatf("vec%0d_wb_beats", i), wb_n, vecs[i].exp_wb);
         checkOutput($sformatf("vec%0d_rd_beats", i), rd_n, vecs[i].exp_rd);
         checkOutput($sformatf("vec%0d_stall_cycles", i), last_stalls, vecs[i].exp_stalls);
         if (i == 4)
            saved = dut_log;
      end

      // The eviction of the 0x100 line carried the merged write.
      checkOutput("evict_beats", saved.size(), 2 * LW);
      for (int k = 0; k < LW && k < saved.size(); k++) begin
         checkOutput($sformatf("evict_wb%0d_addr", k), saved[k].addr, 32'h100 + k * 4);
         checkOutput($sformatf("evict_wb%0d_data", k), saved[k].data, wb_exp[k]);
      end
      for (int k = LW; k < 2 * LW && k < saved.size(); k++)
         checkOutput($sformatf("evict_rd%0d_addr", k - LW), saved[k].addr, 32'h500 + (k - LW) * 4);
      checkCounters("table");

      // Acknowledge held back for five cycles on the first refill beat.
      $display("[TB] refill with delayed acknowledge");
      block_addr = 32'h2000;
      startAccess(1'b0, 1'b1, 32'h2000, 32'h0);
      checkOutput("hold_stall_issue", mem_stall, 32'h1);
      nextCycle();
      checkOutput("hold_we", ram_we, 32'h0);
      for (int c = 0; c < 5; c++) begin
         checkOutput($sformatf("hold%0d_req", c), ram_req, 32'h1);
         checkOutput($sformatf("hold%0d_addr", c), ram_addr, 32'h2000);
         checkOutput($sformatf("hold%0d_stall", c), mem_stall, 32'h1);
         nextCycle();
      end
      block_addr = 32'hFFFF_FFFF;
      finishAccess(1'b0, 32'h2000, 32'h0);
      checkOutput("hold_din", last_din, 32'hDFFF_2000);

      // Reset while the third refill beat is outstanding.
      $display("[TB] reset during refill");
      block_addr = 32'h3048;
      startAccess(1'b0, 1'b1, 32'h3040, 32'h0);
      guard = 0;
      while (!(ram_req && ram_addr == 32'h3048) && guard < 50) begin
         nextCycle();
         guard++;
      end
      checkOutput("abort_reached_beat2", ram_addr, 32'h3048);
      rst = 1'b0;
      #1;
      checkOutput("abort_ram_req", ram_req, 32'h0);
      checkOutput("abort_ram_we", ram_we, 32'h0);
      checkOutput("abort_ram_addr", ram_addr, 32'h0);
      mem_ren = 1'b0;
      #1;
      checkOutput("abort_stall_idle", mem_stall, 32'h0);
      modelReset();
      checkCounters("abort");
      nextCycle();
      rst        = 1'b1;
      block_addr = 32'hFFFF_FFFF;

      // Everything was invalidated, so the old line is refilled again.
      applyStimulus(1'b0, 1'b1, 32'h100, 32'h0);
      checkOutput("refetch_din", last_din, 32'hA0);
      checkOutput("refetch_stall_cycles", last_stalls, 32'd6);
      applyStimulus(1'b0, 1'b1, 32'h108, 32'h0);
      checkOutput("refetch_written_back", last_din, 32'hDEAD);
      checkOutput("refetch_hit_stall", last_stalls, 32'd0);
      checkCounters("refetch");

      // Randomised traffic over a few conflicting lines.
      $display("[TB] randomised accesses");
      stray_en = 1'b1;
      for (int n = 0; n < 150; n++) begin
         ack_pct = int'($urandom_range(40, 100));
         w = 1'($urandom_range(1));
         r = w ? 1'($urandom_range(1)) : 1'b1;
         a = ($urandom_range(3) << 10) | ($urandom_range(3) << 4) |
             ($urandom_range(3) << 2) | $urandom_range(3);
         applyStimulus(w, r, a, $urandom);
      end
      stray_en = 1'b0;
      ack_pct  = 100;
      nextCycle();
      checkOutput("final_stall", mem_stall, 32'h0);
      checkOutput("final_ram_req", ram_req, 32'h0);
      checkCounters("final");

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
